// File: rtl/m_axis_ppf_serializer.sv
// m_axis_ppf_serializer: ping-pong buffers 8-channel PPF output sets and streams them one channel per AXI4-Stream beat.
// Optional PPF_SERIALIZER_SAT_EN: saturate narrowed components instead of wrapping.
module m_axis_ppf_serializer #(
  parameter int DOUT_WIDTH     = 32,
  parameter int SHIFT          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      frame_valid_i,
  input  logic [63:0]               channel0_data_i,
  input  logic [63:0]               channel1_data_i,
  input  logic [63:0]               channel2_data_i,
  input  logic [63:0]               channel3_data_i,
  input  logic [63:0]               channel4_data_i,
  input  logic [63:0]               channel5_data_i,
  input  logic [63:0]               channel6_data_i,
  input  logic [63:0]               channel7_data_i,
  output logic [DOUT_WIDTH-1:0]     M_TDATA,
  output logic                      M_TVALID,
  input  logic                      M_TREADY,
  output logic                      M_TLAST,
  output logic [2:0]                M_TUSER,
  output logic                      overflow_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
  localparam int H = DOUT_WIDTH / 2;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;
  logic [7:0][63:0] din;
  logic [7:0][DOUT_WIDTH-1:0] din_n;
  logic [7:0][DOUT_WIDTH-1:0] slot [2];
  logic [1:0] vld, vld_n, count;
  logic wr_ptr, rd_ptr, hs, rel, cap;
  logic [2:0] beat;

  function automatic logic [H-1:0] narrow(input logic [31:0] x);
`ifdef PPF_SERIALIZER_SAT_EN
    logic [31:0] s;
    s = $signed(x) >>> SHIFT;
    return (s[31:H-1] == '0 || s[31:H-1] == '1) ? s[H-1:0] : {s[31], {(H-1){~s[31]}}};
`else
    return x[SHIFT+H-1:SHIFT];
`endif
  endfunction

  assign din = {channel7_data_i, channel6_data_i, channel5_data_i, channel4_data_i,
                channel3_data_i, channel2_data_i, channel1_data_i, channel0_data_i};

  // Narrowing happens at capture so the slots only hold the bits that are streamed.
  always_comb begin
    for (int i = 0; i < 8; i++) din_n[i] = {narrow(din[i][63:32]), narrow(din[i][31:0])};
  end

  always_comb begin
    count    = {1'b0, vld[0]} + {1'b0, vld[1]};
    M_TVALID = state == SEND;
    M_TUSER  = beat;
    M_TLAST  = M_TVALID && beat == 3'd7;
    M_TDATA  = M_TVALID ? slot[rd_ptr][beat] : '0;
    hs       = M_TVALID && M_TREADY;
    rel      = hs && beat == 3'd7;
    cap      = frame_valid_i && count != 2'd2;
    vld_n    = vld;
    if (cap) vld_n[wr_ptr] = 1'b1;
    if (rel) vld_n[rd_ptr] = 1'b0;
    state_n  = state == IDLE ? (count != 2'd0 ? SEND : IDLE) : (rel && vld_n == 2'b00 ? IDLE : SEND);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      vld        <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat       <= 3'd0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state <= state_n;
      vld   <= vld_n;
      if (cap) wr_ptr <= ~wr_ptr;
      if (rel) rd_ptr <= ~rd_ptr;
      if (hs) beat <= beat + 3'd1;
      if (frame_valid_i && !cap) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && cap) slot[wr_ptr] <= din_n;
  end
endmodule

// File: doc/m_axis_ppf_serializer.md
Name: m_axis_ppf_serializer

Overview:
- Downstream stage of the direct-form polyphase filterbank (PPF). It consumes the eight parallel 64-bit complex DFT outputs (real in [63:32], imag in [31:0]) and streams them out one channel per beat on an AXI4-Stream master interface.
- Each 8-channel output set is captured into a two-slot ping-pong buffer, then serialized as a frame with M_TLAST on channel 7.
- Each component is scaled and narrowed to DOUT_WIDTH/2 bits.

Parameters:
- DOUT_WIDTH, 32, M_TDATA width; real in upper half, imag in lower half; must be even and <= 64.
- SHIFT, 8, right-shift (bit select offset) applied to each 32-bit component before narrowing; 0 <= SHIFT <= 32-DOUT_WIDTH/2.
- DROP_CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- ACLK  input  1  single clock; all logic on rising edge.
- ARESET  input  1  synchronous reset, active-high.
- frame_valid_i  input  1  one-cycle strobe; channel0..7_data_i hold a new set this cycle.
- channel0_data_i .. channel7_data_i  input  64 each  PPF outputs, {real[31:0], imag[31:0]}, signed.
- M_TDATA  output  DOUT_WIDTH  {real_n, imag_n} of current channel.
- M_TVALID  output  1  beat valid.
- M_TREADY  input  1  downstream ready.
- M_TLAST  output  1  high on channel-7 beat.
- M_TUSER  output  3  channel index of current beat (0..7).
- overflow_o  output  1  sticky; set when a frame is dropped.
- drop_cnt_o  output  DROP_CNT_WIDTH  count of dropped frames, saturating at all-ones.

Behaviour:
- Reset (ARESET high at an edge): clears both slots' valid flags, wr_ptr=0, rd_ptr=0, count=0, beat=0, state=IDLE, overflow_o=0, drop_cnt_o=0.
  - Consequence: M_TVALID=0, M_TLAST=0, M_TUSER=0, M_TDATA=0 from the next cycle.
  - Reset mid-frame discards all buffered and in-flight data; no partial frame resumes afterwards.
- Capture: on an edge with frame_valid_i=1 and count<2, all eight inputs are latched into slot[wr_ptr], wr_ptr toggles and count increments.
- Drop: with frame_valid_i=1 and count==2, the frame is discarded, overflow_o is set and drop_cnt_o increments (saturating).
  - Count is evaluated before any same-cycle release, so a strobe on the edge that completes a frame's last beat is still dropped when count==2.
- State machine:
  - IDLE: M_TVALID=0. Go to SEND when count>0.
  - SEND: M_TVALID=1. Data comes from slot[rd_ptr], channel beat.
  - Handshake when M_TVALID && M_TREADY:
    - beat<7: beat++.
    - beat==7: beat=0, rd_ptr toggles, count decrements. Stay in SEND if the post-update count>0 (back-to-back frames, no bubble); otherwise go to IDLE.
  - Simultaneous capture and release on the same edge: count is unchanged.
- Latency: a strobe captured at edge N into an empty buffer gives M_TVALID=1 with channel 0 from edge N+1. Eight beats minimum per frame.
- Stability: while M_TVALID=1 and M_TREADY=0, M_TDATA, M_TUSER and M_TLAST hold constant. Outputs are a mux of registered slot data indexed by the registered rd_ptr and beat. Capture into the other slot never disturbs slot[rd_ptr].
- M_TUSER=beat. M_TLAST = (beat==7) && M_TVALID.
- Narrowing, per 32-bit signed component x, H=DOUT_WIDTH/2: out = x[SHIFT+H-1:SHIFT]. This is truncation toward −inf with wrap on overflow. Real and imag are processed independently.
- frame_valid_i is ignored while ARESET=1.

Optional Feature:
- Macro: PPF_SERIALIZER_SAT_EN.
- Defined: each component saturates instead of wrapping. If x>>>SHIFT exceeds 2^(H-1)-1 the output is 0x7FFF (for H=16). If it is below −2^(H-1) the output is 0x8000. Otherwise the output equals the truncated value.
- Undefined: pure bit-select truncation with wrap, as above. No saturation logic is synthesized.

Test Plan:
- Basic frame: reset, M_TREADY=1. Strobe once with channelk real=k<<8, imag=−(k<<8), SHIFT=8, DOUT_WIDTH=32.
  -> 8 consecutive beats starting the next cycle. M_TDATA = {16'(k), 16'(−k)}, M_TUSER=0..7, M_TLAST only on beat 7, M_TVALID low afterwards.
- Backpressure: M_TREADY toggles 1,0,0,1,... during a frame.
  -> M_TDATA/M_TUSER stable while stalled. Exactly 8 accepted beats, in order, none duplicated.
- Overflow: M_TREADY=0, strobe 3 frames A, B, C.
  -> A and B buffered; C dropped, overflow_o=1, drop_cnt_o=1. Raising M_TREADY streams A then B back-to-back with no idle cycle (16 beats).
- Boundary strobe: with count==2, strobe on the same edge as A's last beat.
  -> frame dropped, drop_cnt_o increments. With count==1 on the same edge, the frame is captured and streaming continues without a bubble.
- Reset mid-frame: assert ARESET for 1 cycle after beat 3 of a frame.
  -> M_TVALID=0 next cycle, overflow_o=0, drop_cnt_o=0. A new strobe afterwards starts at M_TUSER=0.
- Saturation (PPF_SERIALIZER_SAT_EN defined): real=0x7FFF_FFFF, imag=0x8000_0000, SHIFT=8.
  -> M_TDATA=0x7FFF_8000. With the macro undefined -> 0xFFFF_0000.
